// File: rtl/main_memory.sv
// Word-addressed memory with a fixed access latency, abort-on-new-request
// behaviour and saturating read/write completion counters.

package main_memory_pkg;

  // Request payload as latched from the input pins.
  typedef struct packed {
    logic [31:0] data;
    logic [31:0] addr;
    logic        wr;
  } mem_req_t;

endpackage : main_memory_pkg

module main_memory
  import main_memory_pkg::*;
#(
  parameter int unsigned DEPTH     = 1024,
  parameter int unsigned ADDR_BITS = 10,
  parameter int unsigned LATENCY   = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] data,
  input  logic [31:0] addr,
  input  logic        wr,
  output logic        response,
  output logic [31:0] out,
  output logic [15:0] rd_count,
  output logic [15:0] wr_count
);

  localparam int unsigned CNT_W  = 8;
  localparam int unsigned WORD_W = 32;
  localparam int unsigned CNT_W_MAX = 16;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  state_t              state, state_next;
  logic [CNT_W-1:0]    cnt, cnt_next;
  mem_req_t            lat;
  mem_req_t            req_in_c;
  logic                req_c;
  logic                done_c;
  logic                mem_we_c;
  logic [ADDR_BITS-1:0] idx_c;
  logic                unused_addr_c;

  // Power-up contents are all zero; reset deliberately leaves memory alone.
  logic [WORD_W-1:0]   mem [DEPTH] = '{default: '0};

  // Current pin set as a payload, and the word index of the latched request.
  assign req_in_c      = '{data: data, addr: addr, wr: wr};
  assign req_c         = (req_in_c != lat);
  assign idx_c         = lat.addr[ADDR_BITS-1:0];
  assign unused_addr_c = ^lat.addr[31:ADDR_BITS];
  assign mem_we_c      = done_c && lat.wr && !rst;

  // State register and latency counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  // Next-state logic: a changed input set always (re)starts the access.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    done_c     = 1'b0;
    case (state)
      IDLE: begin
        if (req_c) begin
          state_next = BUSY;
          cnt_next   = CNT_W'(LATENCY - 1);
        end
      end
      BUSY: begin
        if (req_c) begin
          cnt_next = CNT_W'(LATENCY - 1);
        end else if (cnt == '0) begin
          done_c     = 1'b1;
          state_next = IDLE;
        end else begin
          cnt_next = cnt - CNT_W'(1);
        end
      end
      default: begin
        state_next = IDLE;
        cnt_next   = '0;
      end
    endcase
  end

  // Request latch, response flag, read/written word and completion counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      lat      <= '0;
      response <= 1'b1;
      out      <= '0;
      rd_count <= '0;
      wr_count <= '0;
    end else begin
      if (req_c) begin
        lat <= req_in_c;
      end
      response <= (state_next == IDLE);
      if (done_c) begin
        if (lat.wr) begin
          out <= lat.data;
          if (wr_count != 16'hFFFF) begin
            wr_count <= wr_count + CNT_W_MAX'(1);
          end
        end else begin
          out <= mem[idx_c];
          if (rd_count != 16'hFFFF) begin
            rd_count <= rd_count + CNT_W_MAX'(1);
          end
        end
      end
    end
  end

  // Memory array: only a completed, non-aborted write changes a word.
  always_ff @(posedge clk) begin
    if (mem_we_c) begin
      mem[idx_c] <= lat.data;
    end
  end

endmodule : main_memory
